des_key_schedule: RTL
=====================

Name: des_key_schedule

Overview:
- Sequential DES key-schedule engine that accepts one 64-bit key and emits the 16 round subkeys, one per handshake, over a valid/ready stream.
- It is the parametrised successor to the combinational permuted-choice stage. It adds the following:
  - PC-1 and PC-2 permutations.
  - Per-round C/D rotations.
  - Encrypt (K1..K16) or decrypt (K16..K1) ordering.
  - Optional odd-parity checking.
  - Output backpressure.
- Sits between the key register file and the DES round datapath.

Parameters:
- PARITY_CHECK, 1, 1 = compute per-byte odd-parity error on accepted key; 0 = parity_err tied 0.
- PARITY_DROP, 0, 1 = a key failing parity emits no subkeys (only parity_err); ignored when PARITY_CHECK=0.
- OUT_REG, 0, 1 = subkey driven from an output register (adds 1 cycle first-key latency); 0 = PC-2 combinational from C/D register.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  64  key; bit i = FIPS 46-3 bit i+1; parity bits at indices 7,15,...,63.
- decrypt  in  1  sampled with key; 1 = emit K16..K1.
- key_valid  in  1  key handshake valid.
- key_ready  out  1  high only in IDLE.
- subkey  out  48  current subkey; bit i = FIPS PC-2 output bit i+1.
- subkey_idx  out  4  FIPS round number minus 1 of the current subkey (15..0 when decrypting).
- subkey_last  out  1  high with the 16th subkey of a key.
- subkey_valid  out  1  output valid.
- subkey_ready  in  1  output ready (backpressure).
- busy  out  1  high when not IDLE.
- parity_err  out  1  one-cycle pulse, cycle after key accept, if any byte of key_in has even parity.

Behaviour:
- Reset: state IDLE, C/D=0, counter=0. Outputs: subkey=0, subkey_idx=0, subkey_valid=0, subkey_last=0, busy=0, parity_err=0, key_ready=1 from the first cycle after reset.
- Reset mid-generation aborts the sequence immediately; no further subkeys are emitted.
- Shift schedule SHIFTS[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Rotation convention: C = PC1 bits [27:0], D = PC1 bits [55:28]. Rotate-left by s: new[i] = old[(i+s) mod 28]. Rotate-right is the inverse.
- Key accept: key_valid and key_ready high in cycle T.
  - Encrypt: CD <= rotl(PC1(key_in), 1).
  - Decrypt: CD <= PC1(key_in), since C16D16 = C0D0.
  - Counter <= 0. decrypt is latched.
- States:
  - IDLE -> GEN on accept.
  - IDLE -> IDLE on accept when PARITY_DROP=1 and parity fails; parity_err still pulses.
  - GEN -> IDLE on output handshake with counter=15.
- GEN behaviour:
  - subkey_valid=1 and subkey = PC2(CD).
  - OUT_REG=0: first subkey visible at T+1. OUT_REG=1: at T+2, with an extra internal LOAD state.
- Output handshake (subkey_valid and subkey_ready), with counter n:
  - Encrypt: CD <= rotl(CD, SHIFTS[n+2]).
  - Decrypt: CD <= rotr(CD, SHIFTS[16-n]).
  - counter <= n+1. No rotation after n=15.
  - subkey_idx = n (encrypt) or 15-n (decrypt). subkey_last = (n==15).
- Backpressure: with subkey_ready low, subkey, subkey_idx and subkey_last hold stable and the CD register does not advance.
- Throughput and ordering:
  - Sustained rate is 1 subkey/cycle with subkey_ready held high.
  - A full key takes 16 output cycles plus 1 accept cycle.
  - After the last handshake, key_ready asserts the next cycle; no same-cycle key overlap.
- After 16 encrypt handshakes the cumulative rotation totals 28, so CD returns to PC1(key); this is an internal assertion.
- key_valid while busy is ignored (key_ready=0); key_in need not be held.

Decomposition:
- Package des_pkg holds:
  - PC1_TABLE[56] and PC2_TABLE[48] constants (FIPS 46-3, 0-based).
  - SHIFTS[16] constant.
  - Half-key width 28 and subkey width 48 localparams.
  - State enum {IDLE, LOAD, GEN}.
- Sub-module des_pc2: combinational 56->48 PC-2 selection, instantiated once.
- PC-1 and rotations stay inline.

Test Plan:
- Encrypt, key 133457799BBCDFF1 (FIPS hex, bench maps FIPS bit k to index k-1), subkey_ready=1 -> first subkey at T+1 = 1B02EFFC7072 with idx 0; 16th = CB3D8B0E17F5 with idx 15, subkey_last=1; key_ready high the next cycle.
- Same key, decrypt=1 -> first subkey CB3D8B0E17F5 with idx 15; last subkey 1B02EFFC7072 with idx 0 and subkey_last=1; full sequence equals the reversed encrypt sequence.
- Encrypt, subkey_ready toggled randomly (e.g. low 3 cycles after each 2nd subkey) -> subkey and idx stable while stalled; all 16 values match the software model.
- Key with byte 0 changed 13->12 (even parity) -> parity_err pulses at T+1. PARITY_DROP=0: 16 subkeys are still emitted. PARITY_DROP=1: subkey_valid stays 0 and key_ready=1 at T+1.
- Assert rst after the 5th subkey handshake -> next cycle subkey_valid=0, busy=0, key_ready=1; a new key then restarts at idx 0.
- Back-to-back keys with key_valid held high -> second key accepted exactly 1 cycle after the first key's subkey_last handshake; key_valid during GEN never alters output.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permuted-choice tables (0-based), shift schedule,
// FSM states and small bit-manipulation helpers.
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GEN  = 2'd2
    } state_t;

    localparam logic [5:0] PC1_TABLE [CD_W] = '{
        6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,
        6'd0,  6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17,
        6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26,
        6'd18, 6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35,
        6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14,
        6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21,
        6'd13, 6'd5,  6'd60, 6'd52, 6'd44, 6'd36, 6'd28,
        6'd20, 6'd12, 6'd4,  6'd27, 6'd19, 6'd11, 6'd3
    };

    localparam logic [5:0] PC2_TABLE [SUBKEY_W] = '{
        6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,
        6'd2,  6'd27, 6'd14, 6'd5,  6'd20, 6'd9,
        6'd22, 6'd18, 6'd11, 6'd3,  6'd25, 6'd7,
        6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
        6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54,
        6'd29, 6'd39, 6'd50, 6'd44, 6'd32, 6'd47,
        6'd43, 6'd48, 6'd38, 6'd55, 6'd33, 6'd52,
        6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31
    };

    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] r;
        r = '0;
        for (int j = 0; j < CD_W; j++) begin
            r[j] = key[PC1_TABLE[j]];
        end
        return r;
    endfunction

    // Bit 0 is the leftmost FIPS bit, so a FIPS left rotation moves bits toward index 0.
    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [1:0] s);
        if (s == 2'd2) begin
            return {x[1:0], x[HALF_W-1:2]};
        end else begin
            return {x[0], x[HALF_W-1:1]};
        end
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [1:0] s);
        if (s == 2'd2) begin
            return {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
        end else begin
            return {x[HALF_W-2:0], x[HALF_W-1]};
        end
    endfunction

    function automatic logic [CD_W-1:0] rotl56(input logic [CD_W-1:0] cd, input logic [1:0] s);
        return {rotl28(cd[CD_W-1:HALF_W], s), rotl28(cd[HALF_W-1:0], s)};
    endfunction

    function automatic logic [CD_W-1:0] rotr56(input logic [CD_W-1:0] cd, input logic [1:0] s);
        return {rotr28(cd[CD_W-1:HALF_W], s), rotr28(cd[HALF_W-1:0], s)};
    endfunction

    function automatic logic key_parity_err(input logic [KEY_W-1:0] key);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            bad = bad | ~(^key[8*b +: 8]);
        end
        return bad;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 selection of a 48-bit round subkey from the 56-bit C/D state.
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]     i_cd,
    output logic [SUBKEY_W-1:0] o_subkey
);

    // Pure bit selection through the PC-2 table.
    always_comb begin
        o_subkey = '0;
        for (int i = 0; i < SUBKEY_W; i++) begin
            o_subkey[i] = i_cd[PC2_TABLE[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: accepts a key, then streams the 16 round subkeys in
// encrypt or decrypt order over a valid/ready handshake.
module des_key_schedule
    import des_pkg::*;
#(
    parameter bit PARITY_CHECK = 1'b1,
    parameter bit PARITY_DROP  = 1'b0,
    parameter bit OUT_REG      = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                decrypt,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          subkey_idx,
    output logic                subkey_last,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic                busy,
    output logic                parity_err
);

    state_t              r_state, w_state_nxt;
    logic [CD_W-1:0]     r_cd, w_cd_nxt, w_pc1, w_pc2_in;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic                r_dec, r_perr;
    logic                w_accept, w_hs, w_key_bad, w_drop;
    logic [SUBKEY_W-1:0] w_pc2_out;

    assign w_accept  = key_valid && (r_state == IDLE);
    assign w_hs      = (r_state == GEN) && subkey_ready;
    assign w_key_bad = PARITY_CHECK && key_parity_err(key_in);
    assign w_drop    = PARITY_DROP && w_key_bad;
    assign w_pc1     = pc1(key_in);

    // Next-state, next C/D and round counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cd_nxt    = r_cd;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    // Decrypt starts from C16D16, which equals C0D0.
                    w_cd_nxt  = decrypt ? w_pc1 : rotl56(w_pc1, SHIFTS[0]);
                    w_cnt_nxt = 4'd0;
                    if (w_drop) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = OUT_REG ? LOAD : GEN;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                w_state_nxt = GEN;
            end
            GEN: begin
                if (w_hs) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = GEN;
                        w_cd_nxt    = r_dec ? rotr56(r_cd, SHIFTS[4'd15 - r_cnt])
                                            : rotl56(r_cd, SHIFTS[r_cnt + 4'd1]);
                    end
                end else begin
                    w_state_nxt = GEN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, C/D, counter, latched direction and parity pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cd    <= '0;
            r_cnt   <= 4'd0;
            r_dec   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cd    <= w_cd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_perr  <= w_accept && w_key_bad;
            if (w_accept) begin
                r_dec <= decrypt;
            end
        end
    end

    des_pc2 u_pc2 (
        .i_cd     (w_pc2_in),
        .o_subkey (w_pc2_out)
    );

    generate
        if (OUT_REG) begin : g_out_reg
            logic [SUBKEY_W-1:0] r_subkey;
            // PC-2 looks at the next C/D so the register holds the subkey of the coming round.
            assign w_pc2_in = w_cd_nxt;
            assign subkey   = r_subkey;
            // Output subkey register, loaded in LOAD and on every non-final handshake.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_subkey <= '0;
                end else if ((r_state == LOAD) || (w_hs && (r_cnt != 4'd15))) begin
                    r_subkey <= w_pc2_out;
                end
            end
        end else begin : g_out_comb
            assign w_pc2_in = r_cd;
            assign subkey   = (r_state == GEN) ? w_pc2_out : '0;
        end
    endgenerate

    assign subkey_valid = (r_state == GEN);
    assign subkey_idx   = (r_state == GEN) ? (r_dec ? (4'd15 - r_cnt) : r_cnt) : 4'd0;
    assign subkey_last  = (r_state == GEN) && (r_cnt == 4'd15);
    assign key_ready    = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign parity_err   = r_perr;

endmodule
